// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer; DIVU datapath under `ifdef MULDIV_DIV_EN
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        mf_req,
    output logic        busy,
    output logic        stall,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Multiply: {partial high, shifting multiplier}. Divide: low half holds the dividend/quotient.
    logic [63:0] acc_q, acc_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] wdata_q, wdata_d;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [31:0] div_rem_next;
    logic [31:0] div_quo_next;

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_shift    = {rem_q, acc_q[31]};
        div_diff     = div_shift - {1'b0, mcand_q};
        // Bit 32 set means the shifted value exceeds any 32-bit divisor; otherwise bit 32 is the borrow.
        div_ok       = div_shift[32] | ~div_diff[32];
        div_rem_next = div_ok ? div_diff[31:0] : div_shift[31:0];
        div_quo_next = {acc_q[30:0], div_ok};
    end
`endif

    // One shift-add multiply step: add multiplicand if the current multiplier LSB is set, shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end

    // Sequencer next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        wdata_d = wdata_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        rem_d    = rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            acc_d   = {32'h0, src_b};
                            mcand_d = src_a;
                            cnt_d   = 6'd0;
`ifdef MULDIV_DIV_EN
                            is_div_d = 1'b0;
                            rem_d    = 32'h0;
`endif
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                            acc_d    = {32'h0, src_a};
                            mcand_d  = src_b;
                            cnt_d    = 6'd0;
                            is_div_d = 1'b1;
                            rem_d    = 32'h0;
                            state_d  = S_RUN;
`else
                            // No divider built: DIVU is dropped and the unit stays idle.
                            state_d = S_IDLE;
`endif
                        end
                        OP_MTHI: begin
                            wdata_d = {src_a, lo_in};
                            state_d = S_WRITE;
                        end
                        OP_MTLO: begin
                            wdata_d = {hi_in, src_a};
                            state_d = S_WRITE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    acc_d = {acc_q[63:32], div_quo_next};
                    rem_d = div_rem_next;
                end else begin
                    acc_d = mul_next;
                end
`else
                acc_d = mul_next;
`endif
                if (cnt_q == 6'd31) begin
                    state_d = S_WRITE;
`ifdef MULDIV_DIV_EN
                    wdata_d = is_div_q ? {div_rem_next, div_quo_next} : mul_next;
`else
                    wdata_d = mul_next;
`endif
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any sequence and clears the write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'h0;
            mcand_q <= 32'h0;
            wdata_q <= 64'h0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            rem_q    <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            wdata_q <= wdata_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign stall      = busy & (start | mf_req);
    assign hilo_we    = (state_q == S_WRITE);
    assign done       = hilo_we;
    assign hilo_wdata = wdata_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed vector bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, hi_in, lo_in;
    logic        mf_req;
    logic        busy, stall, hilo_we, done;
    logic [63:0] hilo_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .mf_req     (mf_req),
        .busy       (busy),
        .stall      (stall),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .done       (done)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp;
        int          lat;   // cycles from accept edge to WRITE; -1 means the op is ignored
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                input logic [63:0] e, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.exp = e; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t mk_div(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
`ifdef MULDIV_DIV_EN
        return mk(2'b01, a, b, 32'h0, 32'h0, e, 32);
`else
        return mk(2'b01, a, b, 32'h0, 32'h0, e, -1);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; hi_in = h; lo_in = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A; hi_in = 32'h0BAD0BAD; lo_in = 32'hF00DF00D;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] prev, wd;
        int we_cnt, first_k, busy_err, done_err, stall_err, limit;
        prev = hilo_wdata;
        wd = 64'h0; we_cnt = 0; first_k = -1; busy_err = 0; done_err = 0; stall_err = 0;
        limit = (v.lat < 0) ? 40 : v.lat + 3;
        issue(v.op, v.a, v.b, v.hi, v.lo);
        for (int k = 0; k <= limit; k++) begin
            @(negedge clk);
            if (busy !== ((v.lat >= 0) && (k <= v.lat))) busy_err++;
            if (done !== hilo_we) done_err++;
            if (stall !== 1'b0) stall_err++;
            if (hilo_we === 1'b1) begin
                we_cnt++;
                if (first_k < 0) begin
                    first_k = k;
                    wd = hilo_wdata;
                end
            end
        end
        check($sformatf("vec%0d write count", idx), 64'(we_cnt), (v.lat < 0) ? 64'd0 : 64'd1);
        check($sformatf("vec%0d busy profile errors", idx), 64'(busy_err), 64'd0);
        check($sformatf("vec%0d done vs hilo_we errors", idx), 64'(done_err), 64'd0);
        check($sformatf("vec%0d stall errors", idx), 64'(stall_err), 64'd0);
        if (v.lat >= 0) begin
            check($sformatf("vec%0d write latency", idx), 64'(first_k), 64'(v.lat));
            check($sformatf("vec%0d write data", idx), wd, v.exp);
            check($sformatf("vec%0d held data", idx), hilo_wdata, v.exp);
        end else begin
            check($sformatf("vec%0d data unchanged", idx), hilo_wdata, prev);
        end
    endtask

    initial begin
        int we_cnt, stall_err;

        reset = 1'b1; start = 1'b0; op = 2'b00; mf_req = 1'b0;
        src_a = 32'h0; src_b = 32'h0; hi_in = 32'h0; lo_in = 32'h0;

        // Reset overrides a simultaneous start.
        @(negedge clk);
        start = 1'b1; op = 2'b10; src_a = 32'h11111111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hilo_we", 64'(hilo_we), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo_wdata", hilo_wdata, 64'h0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post-reset idle", 64'(busy), 64'd0);

        vecs.push_back(mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 32));
        vecs.push_back(mk(2'b00, 32'd3, 32'd5, 0, 0, 64'h0000000F, 32));
        vecs.push_back(mk_div(32'd100, 32'd7, 64'h00000002_0000000E));
        vecs.push_back(mk(2'b10, 32'hDEADBEEF, 32'h0, 32'h99999999, 32'h12345678, 64'hDEADBEEF_12345678, 0));
        vecs.push_back(mk_div(32'd5, 32'd0, 64'h00000005_FFFFFFFF));
        vecs.push_back(mk(2'b00, 32'h00010000, 32'h00010000, 0, 0, 64'h00000001_00000000, 32));
        vecs.push_back(mk_div(32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF));
        vecs.push_back(mk(2'b11, 32'h00C0FFEE, 32'h0, 32'hCAFEF00D, 32'h77777777, 64'hCAFEF00D_00C0FFEE, 0));
        vecs.push_back(mk_div(32'd7, 32'd100, 64'h00000007_00000000));
        vecs.push_back(mk(2'b00, 32'hFFFFFFFF, 32'd2, 0, 0, 64'h00000001_FFFFFFFE, 32));
        vecs.push_back(mk_div(32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF));
        vecs.push_back(mk(2'b00, 32'd0, 32'hDEADBEEF, 0, 0, 64'h0, 32));
        vecs.push_back(mk(2'b00, 32'h00012345, 32'h00000100, 0, 0, 64'h00000000_01234500, 32));

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // mf_req held across a MULTU: stall follows busy, drops in the first idle cycle.
        stall_err = 0;
        issue(2'b00, 32'd3, 32'd5, 0, 0);
        for (int k = 0; k <= 45; k++) begin
            @(negedge clk);
            if (stall !== (mf_req & (k <= 32))) stall_err++;
            if (k == 32) begin
                check("mf stall at write", 64'(stall), 64'd1);
                check("mf write data", hilo_wdata, 64'h0F);
            end
            if (k == 33) check("mf stall after busy", 64'(stall), 64'd0);
            if (k == 5)  mf_req = 1'b1;
            if (k == 40) mf_req = 1'b0;
        end
        check("mf stall profile errors", 64'(stall_err), 64'd0);

        // Second MULTU held while the first is in flight.
        we_cnt = 0;
        issue(2'b00, 32'd3, 32'd5, 0, 0);
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) we_cnt++;
            if (k == 20) check("b2b stall while held", 64'(stall), 64'd1);
            if (k == 32) begin
                check("b2b first we", 64'(hilo_we), 64'd1);
                check("b2b first data", hilo_wdata, 64'h0F);
            end
            if (k == 33) begin
                check("b2b idle busy", 64'(busy), 64'd0);
                check("b2b idle stall", 64'(stall), 64'd0);
            end
            if (k == 34) begin
                check("b2b second accepted", 64'(busy), 64'd1);
                start = 1'b0;
            end
            if (k == 66) begin
                check("b2b second we", 64'(hilo_we), 64'd1);
                check("b2b second data", hilo_wdata, 64'h4);
            end
            if (k == 67) check("b2b end busy", 64'(busy), 64'd0);
            if (k == 10) begin
                start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2;
            end
        end
        check("b2b write count", 64'(we_cnt), 64'd2);

        // Reset in the middle of a MULTU aborts it without a write.
        we_cnt = 0;
        issue(2'b00, 32'd9, 32'd9, 0, 0);
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) we_cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo_wdata", hilo_wdata, 64'h0);
        check("abort hilo_we", 64'(hilo_we), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) we_cnt++;
        end
        check("abort write count", 64'(we_cnt), 64'd0);
        run_vec(100, mk(2'b00, 32'd6, 32'd7, 0, 0, 64'h2A, 32));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
